uart_sram_dump: RTL and testbench

//  Transmitter counterpart of the UART-to-SRAM fill path: streams a contiguous SRAM word region out on
//  the UART TX line, high byte then low byte per word, 8N1. Sits beside the decoder in project,

---
 rtl/dump_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/uart_sram_dump.sv | 146 ++++++++++++++
 tb/tb_uart_sram_dump.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the SRAM-to-UART dump path.
// The PPM header constant is only consumed when UART_DUMP_PPM_HEADER_EN is defined.
package dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_RD_ADDR,
        S_RD_WAIT,
        S_TX_HI,
        S_TX_LO,
        S_DRAIN,
        S_DONE
    } dump_state_t;

    // 8N1 frame: start bit, eight data bits LSB first, stop bit
    localparam int   FRAME_BITS  = 10;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    // "P6\n320 240\n255\n" -- binary PPM header for a 320x240 RGB image
    localparam int PPM_HEADER_LEN = 15;
    localparam logic [7:0] PPM_HEADER [PPM_HEADER_LEN] = '{
        8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
        8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A
    };

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. tx_ready is also high on the final stop-bit cycle so a
// waiting byte starts with no idle gap after the previous frame.
module uart_tx_byte
    import dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock_50,
    input  logic       Reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       UART_TX_O
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic                  active;
    logic [CNT_W-1:0]      baud_cnt;
    logic [3:0]            bit_idx;
    logic [FRAME_BITS-1:0] frame;
    logic                  line;
    logic                  bit_end;
    logic                  frame_end;

    assign bit_end   = active && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end = bit_end && (bit_idx == 4'(FRAME_BITS - 1));
    assign tx_ready  = !active || frame_end;
    assign UART_TX_O = line;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            frame    <= '1;
            line     <= IDLE_LEVEL;
        end else if (tx_ready && tx_valid) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            frame    <= {STOP_LEVEL, tx_data, START_LEVEL};
            line     <= START_LEVEL;
        end else if (frame_end) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            line     <= IDLE_LEVEL;
        end else if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            frame    <= {IDLE_LEVEL, frame[FRAME_BITS-1:1]};
            line     <= frame[1];
        end else if (active) begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_sram_dump.sv
// Streams a contiguous SRAM word region out on UART TX, high byte first.
// Define UART_DUMP_PPM_HEADER_EN to prefix the stream with a 15-byte PPM header.
module uart_sram_dump
    import dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = 18
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_address,
    input  logic [ADDR_W-1:0] Word_count,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic              SRAM_we_n,
    input  logic [15:0]       SRAM_read_data,
    output logic              UART_TX_O,
    output logic              Busy,
    output logic              Done
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    dump_state_t       state, state_next;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] addr_hold;
    logic [LAT_W-1:0]  lat_cnt;
    logic              lat_done;
    logic [15:0]       word;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
`ifdef UART_DUMP_PPM_HEADER_EN
    logic [3:0]        hdr_idx;
`endif

    assign lat_done  = (lat_cnt == LAT_W'(READ_LATENCY - 1));
    // Address is presented in S_RD_ADDR and held through the latency window.
    assign SRAM_address = (state == S_RD_ADDR) ? cur_addr : addr_hold;
    assign SRAM_we_n = 1'b1;
    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            addr_hold <= '0;
            lat_cnt   <= '0;
            word      <= '0;
`ifdef UART_DUMP_PPM_HEADER_EN
            hdr_idx   <= '0;
`endif
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        cur_addr  <= Base_address;
                        remaining <= Word_count;
`ifdef UART_DUMP_PPM_HEADER_EN
                        hdr_idx   <= '0;
`endif
                    end
                end
`ifdef UART_DUMP_PPM_HEADER_EN
                S_HEADER: if (tx_ready) hdr_idx <= hdr_idx + 1'b1;
`endif
                S_RD_ADDR: begin
                    addr_hold <= cur_addr;
                    lat_cnt   <= '0;
                end
                S_RD_WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) word <= SRAM_read_data;
                end
                S_TX_LO: begin
                    if (tx_ready) begin
                        remaining <= remaining - 1'b1;
                        cur_addr  <= cur_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = '0;
        case (state)
            S_IDLE: begin
                if (Start) begin
`ifdef UART_DUMP_PPM_HEADER_EN
                    state_next = S_HEADER;
`else
                    state_next = (Word_count == '0) ? S_DONE : S_RD_ADDR;
`endif
                end
            end
`ifdef UART_DUMP_PPM_HEADER_EN
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = PPM_HEADER[hdr_idx];
                if (tx_ready && (hdr_idx == 4'(PPM_HEADER_LEN - 1)))
                    state_next = (remaining == '0) ? S_DRAIN : S_RD_ADDR;
            end
`endif
            S_RD_ADDR: state_next = S_RD_WAIT;
            S_RD_WAIT: if (lat_done) state_next = S_TX_HI;
            S_TX_HI: begin
                tx_valid = 1'b1;
                tx_data  = word[15:8];
                if (tx_ready) state_next = S_TX_LO;
            end
            S_TX_LO: begin
                tx_valid = 1'b1;
                tx_data  = word[7:0];
                if (tx_ready)
                    state_next = (remaining == ADDR_W'(1)) ? S_DRAIN : S_RD_ADDR;
            end
            // Ready rises on the last stop-bit cycle, so Done lands just after it.
            S_DRAIN: if (tx_ready) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .UART_TX_O(UART_TX_O)
    );

endmodule

// File: tb/tb_uart_sram_dump.sv
// Self-checking bench for uart_sram_dump: SRAM emulator, UART monitor and a
// byte scoreboard. Works with or without UART_DUMP_PPM_HEADER_EN defined.
module tb_uart_sram_dump;

    localparam int C      = 4;
    localparam int ADDR_W = 18;
`ifdef UART_DUMP_PPM_HEADER_EN
    localparam int HDR_N = 15;
`else
    localparam int HDR_N = 0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] count = '0;
    logic [ADDR_W-1:0] sram_address;
    logic              sram_we_n;
    logic [15:0]       sram_read_data;
    logic              tx;
    logic              busy;
    logic              done;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] p1 = '0, p2 = '0;
    logic [7:0]  hdr [15] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
                              8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};

    logic [7:0] exp_q [$];
    int vectors = 0, miscompares = 0;
    int rx_count = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Two-cycle read latency SRAM model
    always @(posedge clk) begin
        p1 <= mem[sram_address];
        p2 <= p1;
    end
    assign sram_read_data = p2;

    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    uart_sram_dump #(
        .CLKS_PER_BIT(C),
        .READ_LATENCY(2),
        .ADDR_W      (ADDR_W)
    ) dut (
        .Clock_50      (clk),
        .Reset         (rst),
        .Start         (start),
        .Base_address  (base),
        .Word_count    (count),
        .SRAM_address  (sram_address),
        .SRAM_we_n     (sram_we_n),
        .SRAM_read_data(sram_read_data),
        .UART_TX_O     (tx),
        .Busy          (busy),
        .Done          (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART monitor: every bit window must hold one level for exactly C cycles.
    initial begin : uart_monitor
        logic [9:0] bits;
        bit width_ok, aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                width_ok = 1'b1;
                aborted  = 1'b0;
                bits     = '0;
                for (int k = 0; k < 10 && !aborted; k++) begin
                    for (int j = 0; j < C && !aborted; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        else if (j == 0) bits[k] = tx;
                        else if (tx !== bits[k]) width_ok = 1'b0;
                    end
                end
                if (!aborted) begin
                    rx_count++;
                    check("bit_width", 32'(width_ok), 1);
                    check("framing", 32'({bits[9], bits[0]}), 2'b10);
                    if (exp_q.size() == 0) check("extra_byte", 32'(bits[8:1]) | 32'h100, 0);
                    else check("rx_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic expect_dump(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < HDR_N; i++) exp_q.push_back(hdr[i]);
        a = b;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[a][15:8]);
            exp_q.push_back(mem[a][7:0]);
            a = a + 1'b1;
        end
    endtask

    task automatic start_dump(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
        @(posedge clk); #1;
        base = b; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base = ADDR_W'($urandom); count = ADDR_W'($urandom);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int t;
        t = 0;
        while (done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(tag, 32'(done), 1);
    endtask

    task automatic finish_job(input string tag, input int d0, input int r0, input int nbytes);
        wait_done({tag, "_done"}, 3000);
        check({tag, "_pending"}, exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_rx_count"}, rx_count - r0, nbytes);
        check({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0, r0, t;
        logic [ADDR_W-1:0] a0;

        mem[18'h00010] = 16'h1234;
        mem[18'h00011] = 16'hABCD;
        mem[18'h00012] = 16'h00FF;
        mem[18'h3FFFF] = 16'hBEEF;
        mem[18'h00000] = 16'hCAFE;
        mem[18'h00020] = 16'h0102;

        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(sram_address), 0);
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // 1: three words
        d0 = done_cnt; r0 = rx_count;
        expect_dump(18'h00010, 18'd3);
        start_dump(18'h00010, 18'd3);
        check("t1_busy", 32'(busy), 1);
        finish_job("t1", d0, r0, HDR_N + 6);

        // 2: zero words
        d0 = done_cnt; r0 = rx_count; a0 = sram_address;
        expect_dump(18'h00000, 18'd0);
        start_dump(18'h00000, 18'd0);
        check("t2_done_next_cycle", 32'(done), (HDR_N == 0) ? 1 : 0);
        finish_job("t2", d0, r0, HDR_N);
        check("t2_addr_unchanged", 32'(sram_address), 32'(a0));

        // 3: address wrap
        d0 = done_cnt; r0 = rx_count;
        expect_dump(18'h3FFFF, 18'd2);
        start_dump(18'h3FFFF, 18'd2);
        finish_job("t3", d0, r0, HDR_N + 4);

        // 4: reset in the middle of the second byte
        r0 = rx_count;
        expect_dump(18'h00010, 18'd3);
        start_dump(18'h00010, 18'd3);
        t = 0;
        while (rx_count == r0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("t4_first_byte", rx_count - r0, 1);
        repeat (4 * C + 2) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_tx_high", 32'(tx), 1);
        check("t4_busy_low", 32'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        d0 = done_cnt; r0 = rx_count;
        repeat (200) @(negedge clk);
        check("t4_no_more_bytes", rx_count - r0, 0);
        check("t4_no_done", done_cnt - d0, 0);
        expect_dump(18'h00010, 18'd3);
        start_dump(18'h00010, 18'd3);
        finish_job("t4_restart", d0, r0, HDR_N + 6);

        // 5: Start while busy is ignored
        d0 = done_cnt; r0 = rx_count;
        expect_dump(18'h00010, 18'd2);
        start_dump(18'h00010, 18'd2);
        repeat (10) @(posedge clk);
        #1;
        base = 18'h3FFFF; count = 18'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_job("t5", d0, r0, HDR_N + 4);

        // 6: single word (header precedes it when enabled)
        d0 = done_cnt; r0 = rx_count;
        expect_dump(18'h00020, 18'd1);
        start_dump(18'h00020, 18'd1);
        finish_job("t6", d0, r0, HDR_N + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
